// File: rtl/pcie_drp_sequencer_if.sv
// Request/response bus and DRP port bundles for the PCIE_2_1 DRP sequencer.
// The requester owns the master side of the request bus; the sequencer owns the master side of the DRP bus.
interface pcie_drp_req_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_mask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (output req_valid, req_op, req_addr, req_wdata, req_mask,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_op, req_addr, req_wdata, req_mask,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface pcie_drp_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              drp_en;
  logic              drp_we;
  logic [ADDR_W-1:0] drp_addr;
  logic [DATA_W-1:0] drp_di;
  logic [DATA_W-1:0] drp_do;
  logic              drp_rdy;

  modport master (output drp_en, drp_we, drp_addr, drp_di,
                  input  drp_do, drp_rdy);
  modport slave  (input  drp_en, drp_we, drp_addr, drp_di,
                  output drp_do, drp_rdy);
endinterface

// File: rtl/pcie_drp_sequencer.sv
// Command-driven DRP master: single read, write and read-modify-write accesses
// to the PCIE_2_1 DRP port, with a bounded wait for DRPRDY and a one-cycle response strobe.
module pcie_drp_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  pcie_drp_req_if.slave   req,
  pcie_drp_if.master      drp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_EN,
    S_RD_WAIT,
    S_WR_EN,
    S_WR_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0]  OP_RD      = 2'b00;
  localparam logic [1:0]  OP_WR      = 2'b01;
  localparam logic [1:0]  OP_RMW     = 2'b10;
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_drp_addr;
  logic [DATA_W-1:0] r_drp_di;
  logic              w_timeout;
  logic [DATA_W-1:0] w_merge;

  assign w_timeout = (r_cnt == TIMEOUT_C);
  assign w_merge   = (drp.drp_do & ~r_mask) | (r_wdata & r_mask);

  // Every output is either a register or a decode of the state register.
  assign req.req_ready = (r_state == S_IDLE);
  assign req.rsp_valid = (r_state == S_RESP);
  assign req.rsp_err   = (r_state == S_RESP) & r_err;
  assign req.rsp_rdata = r_rdata;
  assign drp.drp_en    = (r_state == S_RD_EN) || (r_state == S_WR_EN);
  assign drp.drp_we    = (r_state == S_WR_EN);
  assign drp.drp_addr  = r_drp_addr;
  assign drp.drp_di    = r_drp_di;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next-state default comes first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req.req_valid) begin
          case (req.req_op)
            OP_RD, OP_RMW: w_state_nxt = S_RD_EN;
            OP_WR:         w_state_nxt = S_WR_EN;
            default:       w_state_nxt = S_RESP;
          endcase
        end
      end
      S_RD_EN:   w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (drp.drp_rdy)    w_state_nxt = (r_op == OP_RMW) ? S_WR_EN : S_RESP;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_WR_EN:   w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (drp.drp_rdy || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // DRP address/data only move when an access is launched, so they hold between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= OP_RD;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_drp_addr <= '0;
      r_drp_di   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.req_valid) begin
            r_op    <= req.req_op;
            r_wdata <= req.req_wdata;
            r_mask  <= req.req_mask;
            r_rdata <= '0;
            r_err   <= (req.req_op == 2'b11);
            r_cnt   <= '0;
            if (req.req_op != 2'b11) r_drp_addr <= req.req_addr;
            if (req.req_op == OP_WR) r_drp_di   <= req.req_wdata;
          end
        end
        S_RD_WAIT: begin
          if (drp.drp_rdy) begin
            r_rdata <= drp.drp_do;
            r_cnt   <= '0;
            if (r_op == OP_RMW) r_drp_di <= w_merge;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WR_WAIT: begin
          if (!drp.drp_rdy) begin
            if (w_timeout) r_err <= 1'b1;
            else           r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
